vlsu_txn_tracker: RTL and testbench



---
 rtl/vlsu_txn_tracker.sv | 160 ++++++++++++++++
 tb/tb_vlsu_txn_tracker.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/vlsu_txn_tracker.sv
// ----------------------------------------------------------------------------
// vlsu_txn_tracker
//   Tracks in-flight AXI bursts issued by the vector load/store unit. Every
//   channel (0 = load/AR, 1 = store/AW) is independent. A channel:
//     - gates its address generator toward the AXI cut (full / drain stall),
//     - counts outstanding bursts,
//     - keeps a FIFO of "last burst of instruction" flags, so that the
//       completion of that burst raises a one-cycle insn_complete pulse,
//     - flags completions that arrive with nothing in flight (sticky err).
//
// Ports (per channel unless noted)
//   clk_i, rst_i         clock; synchronous active-high reset (shared)
//   req_valid_i/_last_i  burst request from the address generator
//   req_ready_o          burst accepted toward AXI
//   axi_valid_o/ready_i  AR/AW handshake toward the AXI cut
//   rsp_valid_i/ready_o  burst completion (last R beat / B response)
//   insn_complete_o      registered pulse: last burst of an instruction done
//   outstanding_o        in-flight count, channel c at [c*CntWidth +: CntWidth]
//   pending_o            registered: channel has bursts in flight
//   drain_i              blocks new issue on all channels (shared)
//   idle_o               registered: no channel has bursts in flight (shared)
//   err_o                sticky: completion seen with nothing in flight
// ----------------------------------------------------------------------------

// Per-channel tracker: counter, last-flag FIFO and handshake gating.
module vlsu_txn_chan #(
  parameter int MaxOutstanding = 8,
  parameter int CntWidth       = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                drain_i,
  input  logic                req_valid_i,
  input  logic                req_last_i,
  output logic                req_ready_o,
  output logic                axi_valid_o,
  input  logic                axi_ready_i,
  input  logic                rsp_valid_i,
  output logic                rsp_ready_o,
  output logic                insn_complete_o,
  output logic [CntWidth-1:0] cnt_o,
  output logic                pending_o,
  output logic                pend_nxt_o,
  output logic                err_o
);
  localparam int PtrW = $clog2(MaxOutstanding);

  logic [CntWidth-1:0]       r_cnt;
  logic [PtrW-1:0]           r_wptr, r_rptr;
  logic [MaxOutstanding-1:0] r_last;
  logic                      r_ic, r_pend, r_err;

  logic                w_full, w_empty, w_issue, w_accept;
  logic [CntWidth-1:0] w_cnt_nxt;

  assign w_full   = (r_cnt == CntWidth'(MaxOutstanding));
  assign w_empty  = (r_cnt == '0);

  assign axi_valid_o = req_valid_i & ~w_full & ~drain_i;
  assign req_ready_o = axi_ready_i & ~w_full & ~drain_i;
  assign rsp_ready_o = ~w_empty;

  assign w_issue  = axi_valid_o & axi_ready_i;
  assign w_accept = rsp_valid_i & rsp_ready_o;

  // Simultaneous issue and accept cancel. Issue is blocked when full and
  // accept when empty, so the counter stays in [0, MaxOutstanding].
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_issue && !w_accept)      w_cnt_nxt = r_cnt + CntWidth'(1);
    else if (!w_issue && w_accept) w_cnt_nxt = r_cnt - CntWidth'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_ic   <= 1'b0;
      r_pend <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_pend <= (w_cnt_nxt != '0);
      // Pointers are power-of-two wide, so natural overflow is the wrap.
      if (w_issue)  r_wptr <= r_wptr + PtrW'(1);
      if (w_accept) r_rptr <= r_rptr + PtrW'(1);
      r_ic <= w_accept & r_last[r_rptr];
      if (rsp_valid_i && w_empty) r_err <= 1'b1;
    end
  end

  // Flag storage needs no reset: entries are only read after being written.
  // Push and pop never target the same live entry (full blocks issue).
  always_ff @(posedge clk_i) begin
    if (w_issue) r_last[r_wptr] <= req_last_i;
  end

  assign insn_complete_o = r_ic;
  assign cnt_o           = r_cnt;
  assign pending_o       = r_pend;
  assign pend_nxt_o      = (w_cnt_nxt != '0);
  assign err_o           = r_err;
endmodule

module vlsu_txn_tracker #(
  parameter  int NrChannels     = 2,
  parameter  int MaxOutstanding = 8,
  localparam int CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NrChannels-1:0]          req_valid_i,
  input  logic [NrChannels-1:0]          req_last_i,
  output logic [NrChannels-1:0]          req_ready_o,
  output logic [NrChannels-1:0]          axi_valid_o,
  input  logic [NrChannels-1:0]          axi_ready_i,
  input  logic [NrChannels-1:0]          rsp_valid_i,
  output logic [NrChannels-1:0]          rsp_ready_o,
  output logic [NrChannels-1:0]          insn_complete_o,
  output logic [NrChannels*CntWidth-1:0] outstanding_o,
  output logic [NrChannels-1:0]          pending_o,
  input  logic                           drain_i,
  output logic                           idle_o,
  output logic [NrChannels-1:0]          err_o
);
  logic [NrChannels-1:0] w_pend_nxt;
  logic                  r_idle;

  for (genvar c = 0; c < NrChannels; c++) begin : g_chan
    vlsu_txn_chan #(
      .MaxOutstanding (MaxOutstanding),
      .CntWidth       (CntWidth)
    ) u_chan (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .drain_i         (drain_i),
      .req_valid_i     (req_valid_i[c]),
      .req_last_i      (req_last_i[c]),
      .req_ready_o     (req_ready_o[c]),
      .axi_valid_o     (axi_valid_o[c]),
      .axi_ready_i     (axi_ready_i[c]),
      .rsp_valid_i     (rsp_valid_i[c]),
      .rsp_ready_o     (rsp_ready_o[c]),
      .insn_complete_o (insn_complete_o[c]),
      .cnt_o           (outstanding_o[c*CntWidth +: CntWidth]),
      .pending_o       (pending_o[c]),
      .pend_nxt_o      (w_pend_nxt[c]),
      .err_o           (err_o[c])
    );
  end

  // Registered from next-state counts so idle_o lines up with pending_o.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_idle <= 1'b1;
    else       r_idle <= ~|w_pend_nxt;
  end

  assign idle_o = r_idle;
endmodule

// File: tb/tb_vlsu_txn_tracker.sv
// Directed bench for vlsu_txn_tracker (2 channels, 8 outstanding).
// Each step drives one cycle of inputs and pushes its expected response:
// combinational outputs for that cycle, registered outputs after its edge.
// The monitor pops and compares on falling edges.
module tb_vlsu_txn_tracker;
  localparam int NC = 2;
  localparam int MO = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          drain = 1'b0;
  logic [NC-1:0] rv = '0, rl = '0, ar = '0, sv = '0;
  logic [NC-1:0] req_ready, axi_valid, rsp_ready, ic, pending, err;
  logic [NC*CW-1:0] outstanding;
  logic          idle;

  vlsu_txn_tracker #(.NrChannels(NC), .MaxOutstanding(MO)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_valid_i     (rv),
    .req_last_i      (rl),
    .req_ready_o     (req_ready),
    .axi_valid_o     (axi_valid),
    .axi_ready_i     (ar),
    .rsp_valid_i     (sv),
    .rsp_ready_o     (rsp_ready),
    .insn_complete_o (ic),
    .outstanding_o   (outstanding),
    .pending_o       (pending),
    .drain_i         (drain),
    .idle_o          (idle),
    .err_o           (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] av, rr, sr, err, ic;
    int         o0, o1;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: comb outputs against the record for this cycle, registered
  // outputs against the record of the previous cycle.
  exp_t prv, cur;
  bit   have = 1'b0;
  always @(negedge clk) begin
    if (have) begin
      chk("outstanding0", int'(outstanding[CW-1:0]), prv.o0);
      chk("outstanding1", int'(outstanding[2*CW-1:CW]), prv.o1);
      chk("pending", int'(pending), int'({prv.o1 != 0, prv.o0 != 0}));
      chk("idle", int'(idle), int'(prv.o0 == 0 && prv.o1 == 0));
      chk("err", int'(err), int'(prv.err));
      chk("insn_complete", int'(ic), int'(prv.ic));
    end
    if (q.size() > 0) begin
      cur = q.pop_front();
      chk("axi_valid", int'(axi_valid), int'(cur.av));
      chk("req_ready", int'(req_ready), int'(cur.rr));
      chk("rsp_ready", int'(rsp_ready), int'(cur.sr));
      prv  = cur;
      have = 1'b1;
    end else begin
      have = 1'b0;
    end
  end

  task automatic step(input logic r, d, input logic [1:0] v, l, a, s,
                      input logic [1:0] eav, err_, esr, input int eo0, eo1,
                      input logic [1:0] eerr, eic);
    exp_t e;
    @(posedge clk); #1;
    rst = r; drain = d; rv = v; rl = l; ar = a; sv = s;
    e.av = eav; e.rr = err_; e.sr = esr; e.o0 = eo0; e.o1 = eo1;
    e.err = eerr; e.ic = eic;
    q.push_back(e);
  endtask

  // Last-flag pattern for the wrap test: first 4 fill, then 10 overlapped.
  bit [0:13] P = 14'b10010110001011;

  initial begin
    repeat (2) @(posedge clk);

    // reset state
    step(1,0, 2'b00,2'b00,2'b00,2'b00, 2'b00,2'b00,2'b00, 0,0, 2'b00,2'b00);

    // ch0: 3 bursts, last = 0,0,1, then 3 completions
    step(0,0, 2'b01,2'b00,2'b01,2'b00, 2'b01,2'b01,2'b00, 1,0, 2'b00,2'b00);
    step(0,0, 2'b01,2'b00,2'b01,2'b00, 2'b01,2'b01,2'b01, 2,0, 2'b00,2'b00);
    step(0,0, 2'b01,2'b01,2'b01,2'b00, 2'b01,2'b01,2'b01, 3,0, 2'b00,2'b00);
    step(0,0, 2'b00,2'b00,2'b00,2'b01, 2'b00,2'b00,2'b01, 2,0, 2'b00,2'b00);
    step(0,0, 2'b00,2'b00,2'b00,2'b01, 2'b00,2'b00,2'b01, 1,0, 2'b00,2'b00);
    step(0,0, 2'b00,2'b00,2'b00,2'b01, 2'b00,2'b00,2'b01, 0,0, 2'b00,2'b01);
    step(0,0, 2'b00,2'b00,2'b00,2'b00, 2'b00,2'b00,2'b00, 0,0, 2'b00,2'b00);

    // ch1: fill to 8, 9th blocked, completion reopens next cycle
    for (int i = 0; i < 8; i++)
      step(0,0, 2'b10,2'b00,2'b10,2'b00, 2'b10,2'b10,(i != 0) ? 2'b10 : 2'b00,
           0,i+1, 2'b00,2'b00);
    step(0,0, 2'b10,2'b00,2'b10,2'b00, 2'b00,2'b00,2'b10, 0,8, 2'b00,2'b00);
    step(0,0, 2'b10,2'b00,2'b10,2'b10, 2'b00,2'b00,2'b10, 0,7, 2'b00,2'b00);
    step(0,0, 2'b10,2'b00,2'b10,2'b00, 2'b10,2'b10,2'b10, 0,8, 2'b00,2'b00);

    // ch0: hold count at 4 with overlapped issue/accept across pointer wrap
    for (int k = 0; k < 4; k++)
      step(0,0, 2'b01,{1'b0,P[k]},2'b01,2'b00, 2'b01,2'b01,{1'b1,k != 0},
           k+1,8, 2'b00,2'b00);
    for (int k = 0; k < 10; k++)
      step(0,0, 2'b01,{1'b0,P[4+k]},2'b01,2'b01, 2'b01,2'b01,2'b11,
           4,8, 2'b00,{1'b0,P[k]});
    for (int k = 0; k < 4; k++)
      step(0,0, 2'b00,2'b00,2'b00,2'b01, 2'b00,2'b00,2'b11,
           3-k,8, 2'b00,{1'b0,P[10+k]});

    // ch0: completion with nothing in flight, then issue+completion at zero
    step(0,0, 2'b00,2'b00,2'b00,2'b01, 2'b00,2'b00,2'b10, 0,8, 2'b01,2'b00);
    step(0,0, 2'b01,2'b00,2'b01,2'b01, 2'b01,2'b01,2'b10, 1,8, 2'b01,2'b00);
    step(0,0, 2'b00,2'b00,2'b00,2'b01, 2'b00,2'b00,2'b11, 0,8, 2'b01,2'b00);

    // ch1: retire to 2, then drain with requests pending; idle rises
    for (int k = 0; k < 6; k++)
      step(0,0, 2'b00,2'b00,2'b00,2'b10, 2'b00,2'b00,2'b10, 0,7-k, 2'b01,2'b00);
    step(0,1, 2'b11,2'b00,2'b11,2'b00, 2'b00,2'b00,2'b10, 0,2, 2'b01,2'b00);
    step(0,1, 2'b11,2'b00,2'b11,2'b10, 2'b00,2'b00,2'b10, 0,1, 2'b01,2'b00);
    step(0,1, 2'b11,2'b00,2'b11,2'b10, 2'b00,2'b00,2'b10, 0,0, 2'b01,2'b00);
    step(0,1, 2'b00,2'b00,2'b00,2'b00, 2'b00,2'b00,2'b00, 0,0, 2'b01,2'b00);

    // ch0 to 5, reset mid-flight, late completions set err
    for (int k = 0; k < 5; k++)
      step(0,0, 2'b01,2'b00,2'b01,2'b00, 2'b01,2'b01,{1'b0,k != 0},
           k+1,0, 2'b01,2'b00);
    step(1,0, 2'b00,2'b00,2'b00,2'b00, 2'b00,2'b00,2'b01, 0,0, 2'b00,2'b00);
    step(0,0, 2'b00,2'b00,2'b00,2'b11, 2'b00,2'b00,2'b00, 0,0, 2'b11,2'b00);
    step(0,0, 2'b00,2'b00,2'b00,2'b00, 2'b00,2'b00,2'b00, 0,0, 2'b11,2'b00);

    @(posedge clk); #1;
    rst = 1'b0; drain = 1'b0; rv = '0; rl = '0; ar = '0; sv = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("scoreboard_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
